// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor.
package serial_sub_pkg;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit a - b - bin built from two half subtractors and an OR of their borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .diff (d1),
        .bout (b1)
    );

    half_subtractor u_hs1 (
        .a    (d1),
        .b    (bin),
        .diff (diff),
        .bout (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit a - b with difference and borrow-out.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one bit per cycle LSB first; define SERIAL_SUB_OVERFLOW_EN to add the signed overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_diff;
    logic             bit_bout;
    logic             accept;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);

    // Next state and datapath: load on an accepted start, shift one bit per SHIFT cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = {bit_diff, res_q[WIDTH-1:1]};
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d      = a;
            b_d      = b;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign diff   = res_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;

    // Keep the operand sign bits, since the operand registers are shifted away.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end
    end

    assign ovf = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_q[WIDTH-1]);
`endif

endmodule
